// File: rtl/simframe_gen_multi_if.sv
// Stream bundle for the frame generator: pattern input stream plus frame output stream.
// The generator uses the slave modport; the pattern source and frame consumer use master.
interface simframe_gen_multi_if #(
  parameter int PATTERN_WIDTH = 32,
  parameter int OUTPUT_WIDTH  = 512
);
  logic [PATTERN_WIDTH-1:0] AXIS_IN_TDATA;
  logic                     AXIS_IN_TVALID;
  logic                     AXIS_IN_TREADY;
  logic [OUTPUT_WIDTH-1:0]  AXIS_OUT_TDATA;
  logic                     AXIS_OUT_TVALID;
  logic                     AXIS_OUT_TREADY;
  logic                     AXIS_OUT_TLAST;
  logic                     AXIS_OUT_TUSER;

  modport master (
    output AXIS_IN_TDATA, AXIS_IN_TVALID, AXIS_OUT_TREADY,
    input  AXIS_IN_TREADY, AXIS_OUT_TDATA, AXIS_OUT_TVALID, AXIS_OUT_TLAST, AXIS_OUT_TUSER
  );

  modport slave (
    input  AXIS_IN_TDATA, AXIS_IN_TVALID, AXIS_OUT_TREADY,
    output AXIS_IN_TREADY, AXIS_OUT_TDATA, AXIS_OUT_TVALID, AXIS_OUT_TLAST, AXIS_OUT_TUSER
  );
endinterface

// File: rtl/simframe_gen_multi.sv
// Simulated-sensor frame generator: replicates each accepted pattern across the output bus
// for a configured number of frames, evolving the working pattern per the latched mode.
module simframe_gen_multi #(
  parameter int PATTERN_WIDTH = 32,
  parameter int OUTPUT_WIDTH  = 512,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [CNT_WIDTH-1:0] CYCLES_PER_ROW,
  input  logic [CNT_WIDTH-1:0] ROWS_PER_FRAME,
  input  logic [CNT_WIDTH-1:0] FRAMES_PER_PATTERN,
  input  logic [1:0]           MODE,
  simframe_gen_multi_if.slave  axis,
  output logic [31:0]          FRAME_COUNT,
  output logic                 BUSY
);

  localparam int LANES = OUTPUT_WIDTH / PATTERN_WIDTH;
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PATTERN_WIDTH-1:0] PAT_ONE = {{(PATTERN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                   state_q;
  logic                     rdy_q;
  logic                     vld_q;
  logic                     user_q;
  logic [PATTERN_WIDTH-1:0] base_q;
  logic [PATTERN_WIDTH-1:0] work_q;
  logic [PATTERN_WIDTH-1:0] work_d;
  logic [1:0]               mode_q;
  logic [CNT_WIDTH-1:0]     cyc_q;
  logic [CNT_WIDTH-1:0]     row_q;
  logic [CNT_WIDTH-1:0]     frm_q;
  logic [CNT_WIDTH-1:0]     cyc_rl_q;
  logic [CNT_WIDTH-1:0]     row_rl_q;
  logic [31:0]              fcnt_q;

  logic out_hs;
  logic in_hs;
  logic last_beat;

  // A zero count means "one", so the remaining-count register is loaded with count-1 clamped at 0.
  function automatic logic [CNT_WIDTH-1:0] cnt_m1(input logic [CNT_WIDTH-1:0] x);
    return (x == '0) ? '0 : x - CNT_ONE;
  endfunction

  function automatic logic [PATTERN_WIDTH-1:0] rotl1(input logic [PATTERN_WIDTH-1:0] x);
    return {x[PATTERN_WIDTH-2:0], x[PATTERN_WIDTH-1]};
  endfunction

  // Working-pattern step for a non-final beat of a frame; mode 3 behaves as constant.
  function automatic logic [PATTERN_WIDTH-1:0] step_work(input logic [1:0]               m,
                                                         input logic [PATTERN_WIDTH-1:0] w,
                                                         input logic                     row_end);
    case (m)
      2'd1:    return w + PAT_ONE;
      2'd2:    return row_end ? rotl1(w) : w;
      default: return w;
    endcase
  endfunction

  assign out_hs    = vld_q & axis.AXIS_OUT_TREADY;
  assign last_beat = (cyc_q == '0) && (row_q == '0) && (frm_q == '0);
  assign work_d    = step_work(mode_q, work_q, cyc_q == '0);

  // In EMIT the input is only taken during the final handshake, giving a bubble-free handover.
  assign axis.AXIS_IN_TREADY = rdy_q | ((state_q == EMIT) & out_hs & last_beat);
  assign in_hs               = axis.AXIS_IN_TVALID & axis.AXIS_IN_TREADY;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      vld_q    <= 1'b0;
      user_q   <= 1'b0;
      base_q   <= '0;
      work_q   <= '0;
      mode_q   <= 2'd0;
      cyc_q    <= '0;
      row_q    <= '0;
      frm_q    <= '0;
      cyc_rl_q <= '0;
      row_rl_q <= '0;
      fcnt_q   <= 32'd0;
    end else if (in_hs) begin
      // Pattern acceptance, from IDLE or as the handover at the end of the last frame.
      state_q  <= EMIT;
      rdy_q    <= 1'b0;
      vld_q    <= 1'b1;
      user_q   <= 1'b1;
      base_q   <= axis.AXIS_IN_TDATA;
      work_q   <= axis.AXIS_IN_TDATA;
      mode_q   <= MODE;
      cyc_q    <= cnt_m1(CYCLES_PER_ROW);
      row_q    <= cnt_m1(ROWS_PER_FRAME);
      frm_q    <= cnt_m1(FRAMES_PER_PATTERN);
      cyc_rl_q <= cnt_m1(CYCLES_PER_ROW);
      row_rl_q <= cnt_m1(ROWS_PER_FRAME);
      if (state_q == EMIT) begin
        fcnt_q <= fcnt_q + 32'd1;
      end
    end else begin
      case (state_q)
        IDLE: rdy_q <= 1'b1;
        EMIT: begin
          if (out_hs) begin
            user_q <= 1'b0;
            if (cyc_q != '0) begin
              cyc_q  <= cyc_q - CNT_ONE;
              work_q <= work_d;
            end else begin
              cyc_q <= cyc_rl_q;
              if (row_q != '0) begin
                row_q  <= row_q - CNT_ONE;
                work_q <= work_d;
              end else begin
                fcnt_q <= fcnt_q + 32'd1;
                row_q  <= row_rl_q;
                work_q <= base_q;
                if (frm_q != '0) begin
                  frm_q  <= frm_q - CNT_ONE;
                  user_q <= 1'b1;
                end else begin
                  vld_q   <= 1'b0;
                  rdy_q   <= 1'b1;
                  state_q <= IDLE;
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign axis.AXIS_OUT_TDATA  = {LANES{work_q}};
  assign axis.AXIS_OUT_TVALID = vld_q;
  assign axis.AXIS_OUT_TLAST  = vld_q & (cyc_q == '0);
  assign axis.AXIS_OUT_TUSER  = vld_q & user_q;
  assign FRAME_COUNT          = fcnt_q;
  assign BUSY                 = (state_q == EMIT);

endmodule

// File: tb/tb_simframe_gen_multi.sv
// Directed bench for simframe_gen_multi: pattern streams in each mode, back-to-back handover,
// output stalls, zero counts and mid-frame reset.
module tb_simframe_gen_multi;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] cyc_cfg;
  logic [15:0] row_cfg;
  logic [15:0] frm_cfg;
  logic [1:0]  mode_cfg;
  logic [31:0] fcnt;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] bl[$];
  logic        blast[$];
  logic        buser[$];

  simframe_gen_multi_if #(.PATTERN_WIDTH(32), .OUTPUT_WIDTH(512)) axis ();

  simframe_gen_multi #(.PATTERN_WIDTH(32), .OUTPUT_WIDTH(512), .CNT_WIDTH(16)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .CYCLES_PER_ROW     (cyc_cfg),
    .ROWS_PER_FRAME     (row_cfg),
    .FRAMES_PER_PATTERN (frm_cfg),
    .MODE               (mode_cfg),
    .axis               (axis),
    .FRAME_COUNT        (fcnt),
    .BUSY               (busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk512(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int k);
    logic [31:0] t;
    t = v;
    for (int i = 0; i < k; i++) t = {t[30:0], t[31]};
    return t;
  endfunction

  // Entered and left at the drive point (#1 after a rising edge); one handshake on the input.
  task automatic send(input logic [31:0] pat, input logic [1:0] m, input int c, input int r,
                      input int f);
    int n;
    n = 0;
    axis.AXIS_IN_TDATA  = pat;
    axis.AXIS_IN_TVALID = 1'b1;
    mode_cfg = m;
    cyc_cfg  = 16'(c);
    row_cfg  = 16'(r);
    frm_cfg  = 16'(f);
    #1;
    while (!axis.AXIS_IN_TREADY && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    chk1("send_rdy", axis.AXIS_IN_TREADY, 1'b1);
    @(posedge clk); #1;
    axis.AXIS_IN_TVALID = 1'b0;
    axis.AXIS_IN_TDATA  = 32'h0;
    // Live config changes after acceptance must not affect the running pattern.
    mode_cfg = 2'd2;
    cyc_cfg  = 16'd5;
    row_cfg  = 16'd5;
    frm_cfg  = 16'd5;
    chk1("first_vld", axis.AXIS_OUT_TVALID, 1'b1);
  endtask

  // Collects n beats of a pattern stream whose full length is total beats; index-based model.
  task automatic collect(input int n, input int total, input logic [31:0] base, input logic [1:0] m,
                         input int c, input int r, input bit stall);
    int got, budget, k, rr, cc;
    logic [31:0]  expl;
    logic [511:0] pd;
    logic         pl, pu;
    bit           pend;
    got = 0; budget = 0; pend = 0;
    pd = '0; pl = 1'b0; pu = 1'b0;
    bl.delete(); blast.delete(); buser.delete();
    while (got < n && budget < 300) begin
      axis.AXIS_OUT_TREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (!axis.AXIS_OUT_TVALID) begin
        chk1("stream_vld", axis.AXIS_OUT_TVALID, 1'b1);
        break;
      end
      if (pend) begin
        chk512("hold_data", axis.AXIS_OUT_TDATA, pd);
        chk1("hold_last", axis.AXIS_OUT_TLAST, pl);
        chk1("hold_user", axis.AXIS_OUT_TUSER, pu);
      end
      if (axis.AXIS_OUT_TREADY) begin
        k  = got % (c * r);
        rr = k / c;
        cc = k % c;
        case (m)
          2'd1:    expl = base + 32'(k);
          2'd2:    expl = rotl(base, rr);
          default: expl = base;
        endcase
        chk512("beat_data", axis.AXIS_OUT_TDATA, {16{expl}});
        chk1("beat_last", axis.AXIS_OUT_TLAST, cc == c - 1);
        chk1("beat_user", axis.AXIS_OUT_TUSER, k == 0);
        chk1("emit_in_rdy", axis.AXIS_IN_TREADY, got == total - 1);
        bl.push_back(axis.AXIS_OUT_TDATA[31:0]);
        blast.push_back(axis.AXIS_OUT_TLAST);
        buser.push_back(axis.AXIS_OUT_TUSER);
        got++;
        pend = 0;
      end else begin
        pend = 1;
        pd = axis.AXIS_OUT_TDATA;
        pl = axis.AXIS_OUT_TLAST;
        pu = axis.AXIS_OUT_TUSER;
      end
      @(posedge clk); #1;
      budget++;
    end
    chk32("beat_count", 32'(got), 32'(n));
  endtask

  task automatic idle_chk(input logic [31:0] exp_fc);
    chk1("idle_vld", axis.AXIS_OUT_TVALID, 1'b0);
    chk1("idle_rdy", axis.AXIS_IN_TREADY, 1'b1);
    chk1("idle_busy", busy, 1'b0);
    chk32("frame_count", fcnt, exp_fc);
  endtask

  initial begin
    resetn   = 1'b0;
    cyc_cfg  = 16'd0;
    row_cfg  = 16'd0;
    frm_cfg  = 16'd0;
    mode_cfg = 2'd0;
    axis.AXIS_IN_TDATA   = 32'h0;
    axis.AXIS_IN_TVALID  = 1'b0;
    axis.AXIS_OUT_TREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_vld", axis.AXIS_OUT_TVALID, 1'b0);
    chk1("rst_in_rdy", axis.AXIS_IN_TREADY, 1'b0);
    chk1("rst_last", axis.AXIS_OUT_TLAST, 1'b0);
    chk1("rst_user", axis.AXIS_OUT_TUSER, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_fc", fcnt, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk1("post_rst_rdy", axis.AXIS_IN_TREADY, 1'b1);

    // Mode 0, 4x2x1
    send(32'hA5A5A5A5, 2'd0, 4, 2, 1);
    collect(8, 8, 32'hA5A5A5A5, 2'd0, 4, 2, 1'b0);
    chk1("t1_last3", blast[3], 1'b1);
    chk1("t1_last7", blast[7], 1'b1);
    chk1("t1_user0", buser[0], 1'b1);
    chk32("t1_lane7", bl[7], 32'hA5A5A5A5);
    idle_chk(32'd1);

    // Mode 1, 3x2x2
    send(32'h00000010, 2'd1, 3, 2, 2);
    collect(12, 12, 32'h00000010, 2'd1, 3, 2, 1'b0);
    chk32("t2_lane5", bl[5], 32'h00000015);
    chk32("t2_lane6", bl[6], 32'h00000010);
    chk1("t2_user6", buser[6], 1'b1);
    chk32("t2_lane11", bl[11], 32'h00000015);
    idle_chk(32'd3);

    // Mode 2, 2x3x1
    send(32'h80000001, 2'd2, 2, 3, 1);
    collect(6, 6, 32'h80000001, 2'd2, 2, 3, 1'b0);
    chk32("t3_lane1", bl[1], 32'h80000001);
    chk32("t3_lane2", bl[2], 32'h00000003);
    chk32("t3_lane4", bl[4], 32'h00000006);
    idle_chk(32'd4);

    // Back-to-back handover on the final beat
    send(32'hCAFEF00D, 2'd0, 2, 1, 1);
    collect(1, 2, 32'hCAFEF00D, 2'd0, 2, 1, 1'b0);
    axis.AXIS_IN_TDATA   = 32'h12345678;
    axis.AXIS_IN_TVALID  = 1'b1;
    mode_cfg             = 2'd1;
    cyc_cfg              = 16'd2;
    row_cfg              = 16'd2;
    frm_cfg              = 16'd1;
    axis.AXIS_OUT_TREADY = 1'b1;
    #1;
    chk1("b2b_last", axis.AXIS_OUT_TLAST, 1'b1);
    chk32("b2b_old_lane", axis.AXIS_OUT_TDATA[31:0], 32'hCAFEF00D);
    chk1("b2b_in_rdy", axis.AXIS_IN_TREADY, 1'b1);
    @(posedge clk); #1;
    axis.AXIS_IN_TVALID = 1'b0;
    cyc_cfg = 16'd9;
    row_cfg = 16'd9;
    chk1("b2b_vld", axis.AXIS_OUT_TVALID, 1'b1);
    chk1("b2b_user", axis.AXIS_OUT_TUSER, 1'b1);
    chk32("b2b_fc", fcnt, 32'd5);
    collect(4, 4, 32'h12345678, 2'd1, 2, 2, 1'b0);
    chk32("b2b_lane3", bl[3], 32'h1234567B);
    idle_chk(32'd6);

    // Random output stalls, mode 1 with wrap-around
    send(32'hFFFFFFFE, 2'd1, 3, 2, 2);
    collect(12, 12, 32'hFFFFFFFE, 2'd1, 3, 2, 1'b1);
    chk32("t5_lane2", bl[2], 32'h00000000);
    idle_chk(32'd8);

    // All counts zero, reserved mode
    send(32'h5A5A0000, 2'd3, 0, 0, 0);
    collect(1, 1, 32'h5A5A0000, 2'd3, 1, 1, 1'b0);
    chk1("t6_last", blast[0], 1'b1);
    chk1("t6_user", buser[0], 1'b1);
    idle_chk(32'd9);

    // Reset in the middle of a frame
    send(32'h0BADBEEF, 2'd0, 4, 4, 1);
    collect(3, 16, 32'h0BADBEEF, 2'd0, 4, 4, 1'b0);
    chk32("t7_fc_pre", fcnt, 32'd9);
    chk1("t7_busy_pre", busy, 1'b1);
    resetn = 1'b0;
    #1;
    chk1("t7_rst_vld", axis.AXIS_OUT_TVALID, 1'b0);
    chk32("t7_rst_fc", fcnt, 32'd0);
    chk1("t7_rst_busy", busy, 1'b0);
    chk1("t7_rst_in_rdy", axis.AXIS_IN_TREADY, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk1("t7_rdy", axis.AXIS_IN_TREADY, 1'b1);
    send(32'h00000077, 2'd0, 1, 1, 1);
    collect(1, 1, 32'h00000077, 2'd0, 1, 1, 1'b0);
    idle_chk(32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
